node: RTL and testbench



---
 rtl/node_pkg.sv | 33 +++
 rtl/node_lfsr.sv | 27 ++
 rtl/node.sv | 158 +++++++++++++++
 tb/tb_node.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_pkg.sv
// Shared types, FSM encoding and the 16-bit narrowing helper for the node neuron.
// sat16 saturates when NODE_SATURATE_EN is defined, otherwise it wraps.
package node_pkg;

    localparam int FRAC = 8;

    typedef logic        [7:0]  arg_t;
    typedef logic signed [15:0] fix_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_RESULT,
        ST_ERROR,
        ST_UPDATE,
        ST_PROP
    } state_t;

    function automatic fix_t sat16(input logic signed [47:0] v);
`ifdef NODE_SATURATE_EN
        if (v > 48'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -48'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
`else
        return v[15:0];
`endif
    endfunction

endpackage

// File: rtl/node_lfsr.sv
// Seed-derived initial weights and bias from a 16-bit maximal-length LFSR.
// A pure function of the parameters, so reset can load these values directly.
module node_lfsr
    import node_pkg::*;
#(
    parameter int          N    = 2,
    parameter logic [15:0] SEED = 16'h0000
) (
    output logic [N-1:0][15:0] init_weights,
    output fix_t               init_bias
);

    logic [15:0] lfsr;

    // x^16+x^14+x^13+x^11+1, right-shifting; every value is taken after one step
    always_comb begin
        lfsr         = (SEED == 16'h0000) ? 16'hACE1 : SEED;
        init_weights = '0;
        for (int i = 0; i < N; i++) begin
            lfsr            = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            init_weights[i] = {{11{lfsr[4]}}, lfsr[4:0]};
        end
        lfsr      = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        init_bias = {{11{lfsr[4]}}, lfsr[4:0]};
    end

endmodule

// File: rtl/node.sv
// Trainable linear neuron: Q0.8 arguments x Q8.8 weights + bias -> Q8.8 result, LMS training.
// Define NODE_SATURATE_EN to saturate all narrowing instead of two's-complement wrap.
module node
    import node_pkg::*;
#(
    parameter int          N    = 2,
    parameter int          S    = 2,
    parameter logic [15:0] SEED = 16'h0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               train,
    input  logic               argument_valid,
    input  logic [N-1:0][7:0]  argument_data,
    output logic               argument_ready,
    output logic               result_valid,
    output logic [15:0]        result_data,
    input  logic               result_ready,
    input  logic               error_valid,
    input  logic [15:0]        error_data,
    output logic               error_ready,
    output logic               propagate_valid,
    output logic [N-1:0][15:0] propagate_data,
    input  logic               propagate_ready
);

    localparam int ACC_W = 26 + $clog2(N);
    localparam int IDX_W = $clog2(N + 1);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(N);
    localparam logic [IDX_W-1:0] LAST_TERM = IDX_W'(N - 1);

    state_t                    state;
    state_t                    state_next;
    logic [IDX_W-1:0]          idx;
    logic [SEL_W-1:0]          sel;
    fix_t                      weights [N];
    fix_t                      bias;
    arg_t                      args [N];
    logic                      train_q;
    fix_t                      err;
    logic signed [ACC_W-1:0]   acc;

    logic [N-1:0][15:0]        init_weights;
    fix_t                      init_bias;

    logic signed [15:0]        mul_x;
    logic signed [8:0]         mul_y;
    logic signed [24:0]        mul_p;
    logic signed [31:0]        prop_p;
    fix_t                      weight_next;
    fix_t                      prop_next;
    fix_t                      bias_next;
    fix_t                      result_next;

    node_lfsr #(
        .N    (N),
        .SEED (SEED)
    ) u_lfsr (
        .init_weights (init_weights),
        .init_bias    (init_bias)
    );

    assign sel = idx[SEL_W-1:0];

    // One shared multiplier serves the MAC (w*a) and the weight update (e*a);
    // the back-propagated e*w needs its own product to keep one input per cycle.
    always_comb begin
        mul_x       = (state == ST_UPDATE) ? err : weights[sel];
        mul_y       = {1'b0, args[sel]};
        mul_p       = mul_x * mul_y;
        prop_p      = err * weights[sel];
        weight_next = sat16(48'(weights[sel]) + 48'(mul_p >>> (FRAC + S)));
        prop_next   = sat16(48'(prop_p >>> FRAC));
        bias_next   = sat16(48'(bias) + 48'(err >>> S));
        result_next = sat16(48'(acc >>> FRAC));
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (argument_valid && argument_ready) state_next = ST_MAC;
            ST_MAC:    if (idx == LAST) state_next = ST_RESULT;
            ST_RESULT: if (result_valid && result_ready) state_next = train_q ? ST_ERROR : ST_IDLE;
            ST_ERROR:  if (error_valid && error_ready) state_next = ST_UPDATE;
            ST_UPDATE: if (idx == LAST) state_next = ST_PROP;
            ST_PROP:   if (propagate_valid && propagate_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state; the extra cycle at
    // idx==LAST gives the N+1 edge latency from accept to valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            idx             <= '0;
            acc             <= '0;
            err             <= '0;
            train_q         <= 1'b0;
            bias            <= init_bias;
            argument_ready  <= 1'b0;
            result_valid    <= 1'b0;
            error_ready     <= 1'b0;
            propagate_valid <= 1'b0;
            result_data     <= '0;
            propagate_data  <= '0;
            for (int i = 0; i < N; i++) begin
                weights[i] <= init_weights[i];
                args[i]    <= '0;
            end
        end else begin
            state           <= state_next;
            argument_ready  <= (state_next == ST_IDLE);
            result_valid    <= (state_next == ST_RESULT);
            error_ready     <= (state_next == ST_ERROR);
            propagate_valid <= (state_next == ST_PROP);
            case (state)
                ST_IDLE: begin
                    if (argument_valid && argument_ready) begin
                        for (int i = 0; i < N; i++) begin
                            args[i] <= argument_data[i];
                        end
                        train_q <= train;
                        acc     <= ACC_W'(bias) <<< FRAC;
                        idx     <= '0;
                    end
                end
                ST_MAC: begin
                    if (idx == LAST) begin
                        result_data <= result_next;
                    end else begin
                        acc <= acc + ACC_W'(mul_p);
                        idx <= idx + 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (error_valid && error_ready) begin
                        err <= error_data;
                        idx <= '0;
                    end
                end
                ST_UPDATE: begin
                    if (idx != LAST) begin
                        weights[sel]        <= weight_next;
                        propagate_data[sel] <= prop_next;
                        if (idx == LAST_TERM) begin
                            bias <= bias_next;
                        end
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_node.sv
// Randomised self-checking bench for node against an arithmetic reference neuron.
// The reference follows the NODE_SATURATE_EN build choice for all narrowing.
module tb_node;

    localparam int          N    = 2;
    localparam int          S    = 2;
    localparam logic [15:0] SEED = 16'h0000;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               train = 1'b0;
    logic               argument_valid = 1'b0;
    logic [N-1:0][7:0]  argument_data = '0;
    logic               argument_ready;
    logic               result_valid;
    logic [15:0]        result_data;
    logic               result_ready = 1'b0;
    logic               error_valid = 1'b0;
    logic [15:0]        error_data = '0;
    logic               error_ready;
    logic               propagate_valid;
    logic [N-1:0][15:0] propagate_data;
    logic               propagate_ready = 1'b0;

    int     vectors = 0;
    int     miscompares = 0;
    longint model_w [N];
    longint model_b;

    node #(
        .N    (N),
        .S    (S),
        .SEED (SEED)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .train           (train),
        .argument_valid  (argument_valid),
        .argument_data   (argument_data),
        .argument_ready  (argument_ready),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .result_ready    (result_ready),
        .error_valid     (error_valid),
        .error_data      (error_data),
        .error_ready     (error_ready),
        .propagate_valid (propagate_valid),
        .propagate_data  (propagate_data),
        .propagate_ready (propagate_ready)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint floorShift(input longint x, input int k);
        longint d;
        longint q;
        d = 1;
        for (int j = 0; j < k; j++) d = d * 2;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint narrow(input longint v);
        longint r;
`ifdef NODE_SATURATE_EN
        r = v;
        if (v > 32767) r = 32767;
        if (v < -32768) r = -32768;
`else
        r = ((v % 65536) + 65536) % 65536;
        if (r >= 32768) r = r - 65536;
`endif
        return r;
    endfunction

    function automatic void modelReset();
        int s;
        int fb;
        int v;
        s = (SEED == 16'h0000) ? 'hACE1 : int'(SEED);
        for (int i = 0; i <= N; i++) begin
            fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
            s  = (s >> 1) | (fb << 15);
            v  = s % 32;
            if (v >= 16) v = v - 32;
            if (i < N) model_w[i] = v;
            else model_b = v;
        end
    endfunction

    // One full transaction: inference, optional training round, with hold cycles of backpressure
    task automatic applyStimulus(input logic [N-1:0][7:0] args, input bit do_train,
                                 input bit err_is_target, input longint err_val,
                                 input int hold, output longint obs_result);
        longint acc;
        longint exp_result;
        longint err;
        longint exp_prop [N];
        int     edges;

        acc = model_b * 256;
        for (int i = 0; i < N; i++) acc += model_w[i] * longint'(args[i]);
        exp_result = narrow(floorShift(acc, 8));

        argument_data  = args;
        train          = do_train;
        argument_valid = 1'b1;
        edges = 0;
        while (!argument_ready && edges < 100) begin
            @(posedge clock); #1; edges++;
        end
        checkOutput("arg_ready_wait", longint'(argument_ready), 1);
        @(posedge clock); #1;
        argument_valid = 1'b0;
        train          = ~do_train;
        checkOutput("arg_ready_drop", longint'(argument_ready), 0);

        edges = 0;
        while (!result_valid && edges < 100) begin
            @(posedge clock); #1; edges++;
        end
        checkOutput("result_latency", edges, N + 1);
        for (int h = 0; h < hold; h++) begin
            checkOutput("result_hold_valid", longint'(result_valid), 1);
            checkOutput("result_hold_data", longint'($signed(result_data)), exp_result);
            checkOutput("result_hold_noarg", longint'(argument_ready), 0);
            @(posedge clock); #1;
        end
        checkOutput("result_data", longint'($signed(result_data)), exp_result);
        obs_result = longint'($signed(result_data));
        result_ready = 1'b1;
        @(posedge clock); #1;
        result_ready = 1'b0;
        checkOutput("result_valid_drop", longint'(result_valid), 0);

        if (!do_train) begin
            checkOutput("no_error_ready", longint'(error_ready), 0);
            checkOutput("back_to_idle", longint'(argument_ready), 1);
        end else begin
            err = err_is_target ? (err_val - exp_result) : err_val;
            if (err > 32767) err = 32767;
            if (err < -32768) err = -32768;
            for (int i = 0; i < N; i++) exp_prop[i] = narrow(floorShift(err * model_w[i], 8));

            error_data  = 16'(err);
            error_valid = 1'b1;
            edges = 0;
            while (!error_ready && edges < 100) begin
                @(posedge clock); #1; edges++;
            end
            checkOutput("error_ready_wait", longint'(error_ready), 1);
            @(posedge clock); #1;
            error_valid = 1'b0;
            checkOutput("error_ready_drop", longint'(error_ready), 0);

            edges = 0;
            while (!propagate_valid && edges < 100) begin
                @(posedge clock); #1; edges++;
            end
            checkOutput("prop_latency", edges, N + 1);
            for (int h = 0; h < hold; h++) begin
                checkOutput("prop_hold_valid", longint'(propagate_valid), 1);
                for (int i = 0; i < N; i++)
                    checkOutput($sformatf("prop_hold%0d", i), longint'($signed(propagate_data[i])), exp_prop[i]);
                @(posedge clock); #1;
            end
            for (int i = 0; i < N; i++)
                checkOutput($sformatf("prop%0d", i), longint'($signed(propagate_data[i])), exp_prop[i]);
            propagate_ready = 1'b1;
            @(posedge clock); #1;
            propagate_ready = 1'b0;
            checkOutput("prop_valid_drop", longint'(propagate_valid), 0);
            checkOutput("prop_back_idle", longint'(argument_ready), 1);

            for (int i = 0; i < N; i++)
                model_w[i] = narrow(model_w[i] + floorShift(err * longint'(args[i]), 8 + S));
            model_b = narrow(model_b + floorShift(err, S));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0][7:0] pats [4];
        longint            tgts [4];
        longint            obs;
        longint            diff;

        pats = '{16'h0000, 16'h00FF, 16'hFF00, 16'hFFFF};
        tgts = '{-256, 127, -256, 127};
        modelReset();

        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_arg_ready", longint'(argument_ready), 0);
        checkOutput("rst_result_valid", longint'(result_valid), 0);
        checkOutput("rst_error_ready", longint'(error_ready), 0);
        checkOutput("rst_prop_valid", longint'(propagate_valid), 0);
        checkOutput("rst_result_data", longint'(result_data), 0);
        checkOutput("rst_prop_data", longint'(propagate_data), 0);
        reset = 1'b0;
        checkOutput("arg_ready_before_edge", longint'(argument_ready), 0);
        @(posedge clock); #1;
        checkOutput("arg_ready_after_release", longint'(argument_ready), 1);

        applyStimulus(16'h7F7F, 1'b0, 1'b0, 0, 0, obs);
        applyStimulus(16'hFFFF, 1'b1, 1'b0, 0, 0, obs);
        applyStimulus(16'hFFFF, 1'b0, 1'b0, 0, 0, obs);

        for (int ep = 0; ep < 25; ep++)
            for (int p = 0; p < 4; p++)
                applyStimulus(pats[p], 1'b1, 1'b1, tgts[p], 0, obs);
        for (int p = 0; p < 4; p++) begin
            applyStimulus(pats[p], 1'b0, 1'b0, 0, 0, obs);
            diff = tgts[p] - obs;
            if (diff < 0) diff = -diff;
            checkOutput($sformatf("converged_p%0d", p), longint'(diff <= 4), 1);
        end

        applyStimulus(16'h40C0, 1'b1, 1'b0, -37, 10, obs);

        for (int k = 0; k < 30; k++)
            applyStimulus(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b0,
                          longint'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 3)), obs);

        for (int k = 0; k < 8; k++)
            applyStimulus(16'hFFFF, 1'b1, 1'b0, 32767, 0, obs);
        applyStimulus(16'hFFFF, 1'b0, 1'b0, 0, 0, obs);

        argument_data  = 16'hFFFF;
        train          = 1'b1;
        argument_valid = 1'b1;
        @(posedge clock); #1;
        argument_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst_arg_ready", longint'(argument_ready), 0);
        checkOutput("midrst_result_valid", longint'(result_valid), 0);
        checkOutput("midrst_result_data", longint'(result_data), 0);
        checkOutput("midrst_prop_data", longint'(propagate_data), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        modelReset();
        @(posedge clock); #1;
        checkOutput("midrst_ready_again", longint'(argument_ready), 1);
        applyStimulus(16'h7F7F, 1'b0, 1'b0, 0, 0, obs);
        applyStimulus(16'hA533, 1'b1, 1'b0, 300, 1, obs);
        applyStimulus(16'hA533, 1'b0, 1'b0, 0, 0, obs);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
